// File: rtl/store_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : store_merge_ctrl
// Brief    : Buffers partial-line CPU stores, read-merge-writes 128-bit lines
//            in the L1 data array, and reuses the last written line on a hit.
// Revision : 1.0 - initial release
// ============================================================================
module store_merge_ctrl #(
    parameter int DEPTH      = 2,
    parameter int INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_wdata,
    input  logic [1:0]            req_selbyte,
    input  logic                  inval,
    output logic                  arr_rd_en,
    output logic [INDEX_BITS-1:0] arr_index,
    input  logic [127:0]          arr_rdata,
    output logic                  arr_wr_en,
    output logic [127:0]          arr_wdata,
    output logic                  done,
    output logic                  busy
);

    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one_cnt  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_MERGE = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  sel;
    } entry_t;

    function automatic logic [INDEX_BITS-1:0] line_idx(input logic [15:0] a);
        return a[4+INDEX_BITS-1:4];
    endfunction

    function automatic logic [127:0] merge_line(input logic [127:0] line, input entry_t e);
        logic [127:0] r;
        logic [6:0]   b;
        r = line;
        b = {e.addr[3:1], 4'b0000};
        case (e.sel)
            2'b11:   r[b +: 16]         = e.wdata;
            2'b10:   r[(b + 7'd8) +: 8] = e.wdata[15:8];
            2'b01:   r[b +: 8]          = e.wdata[7:0];
            default: r                  = line;
        endcase
        return r;
    endfunction

    entry_t                fifo_mem [DEPTH];
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, w_rd_ptr_nx;
    logic [c_cnt_w-1:0]    count_q, count_d;
    state_t                state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [INDEX_BITS-1:0] hold_index_q, hold_index_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [127:0]          line_q, line_d;
    logic                  src_rd_q, src_rd_d;

    logic   w_push, w_pop, w_cand_valid, w_hold_ok, w_hit;
    entry_t w_req_entry, w_head, w_next, w_cand;
    state_t w_choice;

    assign req_ready   = (count_q != c_full_cnt);
    assign w_push      = req_valid && req_ready;
    assign w_pop       = (state_q == S_WRITE);
    assign w_req_entry = '{addr: req_addr, wdata: req_wdata, sel: req_selbyte};
    assign w_rd_ptr_nx = rd_ptr_q + c_ptr_one;
    assign w_head      = fifo_mem[rd_ptr_q];
    assign w_next      = fifo_mem[w_rd_ptr_nx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= w_req_entry;
        end
    end

    // Candidate for the next store: an entry arriving this cycle is bypassed
    // straight into the decision when it will become the head after this edge.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand       = w_req_entry;
        w_hold_ok    = hold_valid_q;
        if (state_q == S_WRITE) begin
            w_hold_ok = 1'b1;
            if (count_q > c_one_cnt) begin
                w_cand_valid = 1'b1;
                w_cand       = w_next;
            end else begin
                w_cand_valid = w_push;
            end
        end else if (count_q != '0) begin
            w_cand_valid = 1'b1;
            w_cand       = w_head;
        end else begin
            w_cand_valid = w_push;
        end
        w_hit    = w_hold_ok && !inval && (line_idx(w_cand.addr) == hold_index_q);
        w_choice = !w_cand_valid ? S_IDLE : (w_hit ? S_MERGE : S_READ);
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        hold_valid_d = hold_valid_q;
        hold_index_d = hold_index_q;
        line_d       = line_q;
        src_rd_d     = 1'b0;
        arr_rd_en    = 1'b0;
        arr_wr_en    = 1'b0;
        arr_index    = index_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end

        case (state_q)
            S_IDLE: begin
                state_d = w_choice;
            end
            S_READ: begin
                arr_rd_en = 1'b1;
                arr_index = line_idx(w_head.addr);
                src_rd_d  = 1'b1;
                state_d   = S_MERGE;
            end
            S_MERGE: begin
                line_d       = merge_line(src_rd_q ? arr_rdata : line_q, w_head);
                hold_index_d = line_idx(w_head.addr);
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                arr_wr_en    = 1'b1;
                arr_index    = hold_index_q;
                rd_ptr_d     = w_rd_ptr_nx;
                hold_valid_d = 1'b1;
                state_d      = w_choice;
            end
            default: state_d = S_IDLE;
        endcase

        // An external change to the array always wins over a fresh hold.
        if (inval) begin
            hold_valid_d = 1'b0;
        end
        index_d = arr_index;
    end

    assign arr_wdata = line_q;
    assign done      = arr_wr_en;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_index_q <= '0;
            index_q      <= '0;
            line_q       <= '0;
            src_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_index_q <= hold_index_d;
            index_q      <= index_d;
            line_q       <= line_d;
            src_rd_q     <= src_rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_merge_ctrl
// Brief    : Scoreboard bench for store_merge_ctrl with a behavioural array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_merge_ctrl;

    localparam logic [127:0] c_base = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [15:0]  req_addr = '0;
    logic [15:0]  req_wdata = '0;
    logic [1:0]   req_selbyte = '0;
    logic         inval = 1'b0;
    logic         arr_rd_en;
    logic [2:0]   arr_index;
    logic [127:0] arr_rdata = '0;
    logic         arr_wr_en;
    logic [127:0] arr_wdata;
    logic         done;
    logic         busy;

    store_merge_ctrl #(.DEPTH(2), .INDEX_BITS(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_selbyte(req_selbyte),
        .inval(inval),
        .arr_rd_en(arr_rd_en), .arr_index(arr_index), .arr_rdata(arr_rdata),
        .arr_wr_en(arr_wr_en), .arr_wdata(arr_wdata),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   idx;
        logic [127:0] line;
    } exp_t;

    exp_t         sb_q[$];
    int           rd_cyc_q[$];
    int           done_cyc_q[$];
    logic [2:0]   rd_idx_q[$];
    logic [127:0] array_m [8];
    logic [127:0] shadow [8];
    logic [127:0] last_wdata = '0;
    int           cyc = 0;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    int           n_total = 0;
    int           n_bad = 0;
    logic         mon_en = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural single-ported array: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arr_rd_en === 1'b1) arr_rdata <= array_m[arr_index];
        if (arr_wr_en === 1'b1) array_m[arr_index] <= arr_wdata;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (arr_rd_en || arr_wr_en || done)
                check_val("rd_wr_excl", 128'(arr_rd_en & arr_wr_en), 128'(0));
            if (arr_rd_en) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                rd_idx_q.push_back(arr_index);
            end
            if (done) check_val("done_has_wr", 128'(arr_wr_en), 128'(1));
            if (arr_wr_en) begin
                exp_t e;
                wr_cnt++;
                done_cyc_q.push_back(cyc);
                last_wdata = arr_wdata;
                check_val("done_pulse", 128'(done), 128'(1));
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 128'(sb_q.size()), 128'(1));
                end else begin
                    e = sb_q.pop_front();
                    check_val("wr_index", 128'(arr_index), 128'(e.idx));
                    check_val("wr_data", arr_wdata, e.line);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
        logic [127:0] m;
        logic [127:0] v;
        exp_t         e;
        m = {112'b0, {8{s[1]}}, {8{s[0]}}} << (16 * a[3:1]);
        v = {8{d}};
        e.idx  = a[6:4];
        e.line = (shadow[a[6:4]] & ~m) | (v & m);
        shadow[a[6:4]] = e.line;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s, output int acc);
        int tries;
        tries = 0;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_selbyte = s;
        while (!req_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check_val("accept", 128'(req_ready), 128'(1));
        acc = cyc;
        push_exp(a, d, s);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        req_valid = 1'b0;
        while ((sb_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val("idle_sb_left", 128'(sb_q.size()), 128'(0));
        check_val("idle_busy", 128'(busy), 128'(0));
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete();
        done_cyc_q.delete();
        rd_idx_q.delete();
    endtask

    initial begin
        int n, n2, n3, k, wr_before, rd_before;
        for (int i = 0; i < 8; i++) begin
            array_m[i] = c_base;
            shadow[i]  = c_base;
        end

        // Reset with a request held high: nothing may be enqueued
        reset_n = 1'b0; req_valid = 1'b1; req_addr = 16'h0036; req_wdata = 16'h1111; req_selbyte = 2'b11;
        repeat (3) @(negedge clk);
        reset_n = 1'b1; req_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 128'(req_ready), 128'(1));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_strobes", 128'({arr_rd_en, arr_wr_en, done}), 128'(0));
        check_val("rst_index", 128'(arr_index), 128'(0));
        check_val("rst_wdata", arr_wdata, 128'(0));
        repeat (4) @(negedge clk);
        check_val("rst_no_enq", 128'(rd_cnt + wr_cnt), 128'(0));

        // Word store, miss path timing
        clear_logs();
        send(16'h0036, 16'hBEEF, 2'b11, n);
        wait_idle(30);
        check_val("word_rd_n", 128'(rd_cyc_q.size()), 128'(1));
        check_val("word_done_n", 128'(done_cyc_q.size()), 128'(1));
        if (rd_cyc_q.size() == 1) begin
            check_val("word_rd_cyc", 128'(rd_cyc_q[0]), 128'(n + 1));
            check_val("word_rd_idx", 128'(rd_idx_q[0]), 128'(3));
        end
        if (done_cyc_q.size() == 1) check_val("word_done_cyc", 128'(done_cyc_q[0]), 128'(n + 3));
        check_val("word_line", last_wdata, 128'h0011223344556677BEEFAABBCCDDEEFF);

        // Byte lanes and the no-lane write-back
        send(16'h007E, 16'h5A00, 2'b10, n);
        wait_idle(30);
        check_val("hi_byte_line", last_wdata, 128'h5A112233445566778899AABBCCDDEEFF);
        send(16'h0000, 16'h003C, 2'b01, n);
        wait_idle(30);
        check_val("lo_byte_line", last_wdata, 128'h00112233445566778899AABBCCDDEE3C);
        send(16'h0054, 16'hDEAD, 2'b00, n);
        wait_idle(30);
        check_val("no_lane_line", last_wdata, c_base);

        // Held-line hit: second store skips the array read
        clear_logs();
        rd_before = rd_cnt;
        send(16'h0030, 16'hFFFF, 2'b11, n);
        send(16'h0032, 16'h1234, 2'b11, n2);
        wait_idle(30);
        check_val("hit_rd_cnt", 128'(rd_cnt - rd_before), 128'(1));
        check_val("hit_done_n", 128'(done_cyc_q.size()), 128'(2));
        if (done_cyc_q.size() == 2) begin
            check_val("hit_done0", 128'(done_cyc_q[0]), 128'(n + 3));
            check_val("hit_done1", 128'(done_cyc_q[1]), 128'(n + 5));
        end
        check_val("hit_words", 128'(last_wdata[31:0]), 128'(32'h1234FFFF));

        // Invalidate during the first write forces a re-read
        send(16'h0060, 16'h0F0F, 2'b11, n);
        wait_idle(30);
        clear_logs();
        rd_before = rd_cnt;
        send(16'h0030, 16'hAAAA, 2'b11, n);
        send(16'h0032, 16'h5555, 2'b11, n2);
        req_valid = 1'b0;
        k = 0;
        while (!arr_wr_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        wait_idle(30);
        check_val("inv_rd_cnt", 128'(rd_cnt - rd_before), 128'(2));
        if (done_cyc_q.size() == 2) begin
            check_val("inv_done0", 128'(done_cyc_q[0]), 128'(n + 3));
            check_val("inv_done1", 128'(done_cyc_q[1]), 128'(n + 6));
        end else begin
            check_val("inv_done_n", 128'(done_cyc_q.size()), 128'(2));
        end

        // Back-pressure with a two-entry FIFO
        clear_logs();
        send(16'h0010, 16'hA001, 2'b11, n);
        send(16'h0022, 16'hA002, 2'b11, n2);
        check_val("bp_full_ready", 128'(req_ready), 128'(0));
        send(16'h0044, 16'hA003, 2'b11, n3);
        req_valid = 1'b0;
        check_val("bp_third_acc", 128'(n3), 128'(n + 4));
        wait_idle(40);
        check_val("bp_done_n", 128'(done_cyc_q.size()), 128'(3));

        // Reset during MERGE aborts without an array write
        send(16'h0050, 16'h7777, 2'b11, n);
        req_valid = 1'b0;
        k = 0;
        while (!arr_rd_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        wr_before = wr_cnt;
        repeat (6) @(negedge clk);
        check_val("abort_no_wr", 128'(wr_cnt - wr_before), 128'(0));
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_ready", 128'(req_ready), 128'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/store_merge_ctrl.md
# store_merge_ctrl

Sequencer for partial-line stores into the L1 data array. Buffers CPU store requests (word, high byte or low byte) in a small FIFO, reads the 128-bit line from the data array, merges the new data into the addressed word/byte lane, and writes the line back. Holds the last written line so back-to-back stores to the same index skip the array read. Sits between the CPU store port and the single-ported data array, upstream of the array write mux.

## Interface

- DEPTH, 2: store FIFO entries (power of two, ≥2)
- INDEX_BITS, 3: line index width; index = addr[4+INDEX_BITS-1:4]

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  FIFO can accept; = !full
- req_addr  in  16  byte address; [3:1] word offset, [0] ignored
- req_wdata  in  16  store data
- req_selbyte  in  2  11 word, 10 high byte, 01 low byte, 00 no lanes
- inval  in  1  array line contents changed externally; drop held line
- arr_rd_en  out  1  array read strobe
- arr_index  out  INDEX_BITS  array index for read/write
- arr_rdata  in  128  read data, valid the cycle after arr_rd_en
- arr_wr_en  out  1  array write strobe
- arr_wdata  out  128  merged line
- done  out  1  one-cycle pulse per retired store
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation

- Reset (reset_n low at edge): FIFO empty, state IDLE, hold_valid=0, line_q=0. Outputs after reset: req_ready=1, arr_rd_en=0, arr_wr_en=0, done=0, busy=0, arr_index=0, arr_wdata=0. Requests during reset cycles are dropped. Reset mid-operation aborts with no array write.
- Enqueue on req_valid && req_ready; entry = {addr, wdata, selbyte}. FIFO in order; pop only in WRITE.
- FSM states:
  - IDLE: FIFO non-empty -> MERGE if hold_valid && head index == hold_index && !inval, else READ.
  - READ: arr_rd_en=1, arr_index=head index; -> MERGE.
  - MERGE: source = arr_rdata if entered from READ, else line_q; line_q <= merge(source, head); hold_index <= head index; -> WRITE.
  - WRITE: arr_wr_en=1, arr_index=hold_index, arr_wdata=line_q; done=1; pop head; hold_valid<=1 (unless inval this cycle). Next: FIFO has another entry (after pop) -> same choice as IDLE; else IDLE.
- Merge, off=addr[3:1], b=16*off: 11 -> line[b+15:b]=wdata; 10 -> line[b+15:b+8]=wdata[15:8]; 01 -> line[b+7:b]=wdata[7:0]; 00 -> line unchanged, still written back. All other bits preserved.
- inval: any cycle clears hold_valid; the decision taken in the same cycle uses READ. inval in WRITE overrides set.
- arr_index and arr_wdata hold last value when strobes low.

## Timing

- Empty FIFO, IDLE, accept at cycle N: READ N+1, MERGE N+2, WRITE/done N+3. Held-line hit: MERGE N+1, WRITE N+2.
- Sustained throughput: 3 cycles/store (miss on hold), 2 cycles/store (hit).
- Full: req_ready=0; pop in WRITE raises req_ready next cycle (registered count). Enqueue and pop same cycle when not full: count unchanged.
- Store sequences issue only one array op per cycle; rd_en and wr_en never both high.

## Test plan

- Reset: hold reset_n low 3 cycles with req_valid=1 -> no enqueue, req_ready=1, busy=0 after release, no strobes.
- Word store: addr 16'h0036, selbyte 11, wdata 16'hBEEF, arr_rdata 128'h00112233445566778899AABBCCDDEEFF -> rd_en at N+1 index 3, wr_en at N+3 with arr_wdata 128'h0011223344556677BEEFAABBCCDDEEFF, done at N+3.
- Byte lanes: addr 16'h007E sel 10 wdata 16'h5A00 -> 128'h5A11...EEFF at index 7; addr 16'h0000 sel 01 wdata 16'h003C -> ...CCDDEE3C; sel 00 -> line written unchanged.
- Hold hit: stores to 16'h0030 (FFFF, sel 11) then 16'h0032 (1234, sel 11) back-to-back -> one arr_rd_en only; second write has words 1 and 0 = 1234, FFFF; done at N+3 and N+5.
- inval: same pair with inval pulsed during first WRITE -> second store re-reads (two rd_en pulses).
- Back-pressure: 3 requests back-to-back with DEPTH=2 -> req_ready low after 2nd accept, third accepted after first WRITE; three done pulses in order, reset asserted mid-MERGE -> no wr_en, FIFO empty.
